// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register master.
//   state_t   : controller states
//   RW_READ / RW_WRITE : value of frame bit 7 selecting the access type
//   ADDR_W    : slave register address width
package spi_pkg;

    localparam int   ADDR_W   = 7;
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } state_t;

endpackage

// File: rtl/spi_reg_master_if.sv
// Request/response bus of the SPI register master.
//   req_valid/req_ready : handshake, transfer when both high
//   req_rw, req_addr, req_wdata : access type, slave address, write data
//   rsp_valid : one-cycle pulse at frame end
//   rsp_rdata : data captured on the last read frame
// modport master : the requester side; modport slave : the SPI master block.
interface spi_reg_master_if #(
    parameter int NBIT = 8
);
    import spi_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [NBIT-1:0]   req_wdata;
    logic              rsp_valid;
    logic [NBIT-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI clock.
//   clk, rst : system clock, synchronous active-high reset
//   en       : count while high; counter parks at 0 while low
//   tick     : high for one cycle every DIV enabled cycles, first one on
//              the DIV-th enabled cycle
module spi_clk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV + 1);

    logic [CNT_W-1:0] cnt;

    // 0 marks the first enabled cycle, so the first load is one short of
    // the reload after a tick; terminal count is 1.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= CNT_W'(DIV - 1);
        end else if (cnt == CNT_W'(1)) begin
            cnt <= CNT_W'(DIV);
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = en && (cnt == CNT_W'(1));

endmodule

// File: rtl/spi_reg_master.sv
// SPI register-access master: frame = {rw, addr[6:0]} header then NBIT data
// bits, MSB first, sclk idle low, data sampled by the slave on rising sclk.
//   clk, rst   : system clock, synchronous active-high reset
//   bus        : request/response interface (slave modport)
//   sclk, mosi, cs : SPI outputs (cs active-low)
//   miso       : SPI data in
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | cs high, req_ready high, waiting for a request
// ST_SETUP | cs low, sclk low for 2*DIV cycles before the first bit
// ST_SHIFT | shifting 8+NBIT bits, each DIV low + DIV high cycles
// ST_GAP   | cs high for CS_GAP cycles, rsp_valid pulses on 2nd cycle
module spi_reg_master
    import spi_pkg::*;
#(
    parameter int NBIT   = 8,
    parameter int DIV    = 4,
    parameter int CS_GAP = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_reg_master_if.slave   bus,
    output logic              sclk,
    output logic              mosi,
    output logic              cs,
    input  logic              miso
);

    localparam int FRAME = 8 + NBIT;
    localparam int BIT_W = $clog2(FRAME + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);

    state_t           state;
    logic [FRAME-1:0] tx_sh;
    logic [NBIT-1:0]  rx_sh;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             phase;
    logic             is_write;
    logic             rsp_pend;
    logic             div_en;
    logic             tick;

    assign div_en = (state == ST_SETUP) || (state == ST_SHIFT);

    spi_clk_div #(.DIV(DIV)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cs            <= 1'b1;
            sclk          <= 1'b0;
            mosi          <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            tx_sh         <= '0;
            rx_sh         <= '0;
            bit_cnt       <= '0;
            gap_cnt       <= '0;
            phase         <= 1'b0;
            is_write      <= 1'b0;
            rsp_pend      <= 1'b0;
        end else begin
            // Response is issued one cycle after cs rises.
            bus.rsp_valid <= rsp_pend;
            rsp_pend      <= 1'b0;
            if (rsp_pend && !is_write) begin
                bus.rsp_rdata <= rx_sh;
            end

            case (state)
                ST_IDLE: begin
                    cs   <= 1'b1;
                    sclk <= 1'b0;
                    mosi <= 1'b0;
                    if (bus.req_valid && bus.req_ready) begin
                        // Read frames shift zeros in the data phase.
                        tx_sh         <= {bus.req_rw, bus.req_addr,
                                          (bus.req_rw == RW_WRITE) ? bus.req_wdata : '0};
                        is_write      <= (bus.req_rw == RW_WRITE);
                        bus.req_ready <= 1'b0;
                        cs            <= 1'b0;
                        phase         <= 1'b0;
                        state         <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (tick) begin
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            phase   <= 1'b0;
                            mosi    <= tx_sh[FRAME-1];
                            tx_sh   <= {tx_sh[FRAME-2:0], 1'b0};
                            bit_cnt <= BIT_W'(FRAME - 1);
                            state   <= ST_SHIFT;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            sclk  <= 1'b1;
                            phase <= 1'b1;
                            // bit_cnt counts remaining bits; below NBIT is the data phase.
                            if (bit_cnt < BIT_W'(NBIT)) begin
                                rx_sh <= {rx_sh[NBIT-2:0], miso};
                            end
                        end else begin
                            sclk  <= 1'b0;
                            phase <= 1'b0;
                            if (bit_cnt == '0) begin
                                cs       <= 1'b1;
                                mosi     <= 1'b0;
                                rsp_pend <= 1'b1;
                                gap_cnt  <= GAP_W'(CS_GAP - 1);
                                state    <= ST_GAP;
                            end else begin
                                mosi    <= tx_sh[FRAME-1];
                                tx_sh   <= {tx_sh[FRAME-2:0], 1'b0};
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        bus.req_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master with a behavioural SPI slave.
// Slave map: 0x01 reads 0xA5, 0x03 reads 0xFF, 0x05 is a writable register;
// any other address leaves miso idling high.
module tb_spi_reg_master;

    localparam int NBIT   = 8;
    localparam int DIV    = 4;
    localparam int CS_GAP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk, mosi, cs;
    logic miso_r = 1'b1;

    spi_reg_master_if #(.NBIT(NBIT)) bus ();

    spi_reg_master #(.NBIT(NBIT), .DIV(DIV), .CS_GAP(CS_GAP)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .sclk (sclk),
        .mosi (mosi),
        .cs   (cs),
        .miso (miso_r)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int hs_count = 0;
    int rsp_count = 0;
    int run = 0;
    int min_run = 100000;
    int ready_bad = 0;
    logic mon_en = 1'b0;

    int          bitn = 0;
    logic [15:0] mosi_frame = '0;
    logic [7:0]  hdr = '0;
    logic [7:0]  reg5 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic slave_bit(input logic [7:0] h, input int k, input logic [7:0] r5);
        logic [7:0] v;
        if (h[7]) return 1'b1;
        case (h[6:0])
            7'h01:   v = 8'hA5;
            7'h03:   v = 8'hFF;
            7'h05:   v = r5;
            default: v = 8'hFF;
        endcase
        return v[7-k];
    endfunction

    // Cycle/handshake bookkeeping; hs_cyc is the cycle number after the handshake edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.req_valid && bus.req_ready && !rst) begin
            hs_cyc   <= cyc + 1;
            hs_count <= hs_count + 1;
        end
    end

    always @(negedge clk) begin
        if (bus.rsp_valid) rsp_count++;
        if (cs) begin
            run++;
        end else begin
            if (mon_en && run > 0 && run < min_run) min_run = run;
            run = 0;
        end
        if (bus.req_ready && (!cs || sclk)) ready_bad++;
    end

    // Slave receive side: frame restarts on cs fall, mosi sampled on sclk rise.
    always @(negedge cs or posedge sclk) begin
        if (!sclk) begin
            bitn       = 0;
            mosi_frame = '0;
        end else if (!cs) begin
            mosi_frame = {mosi_frame[14:0], mosi};
            bitn++;
        end
    end

    // Slave transmit side: next data bit presented on sclk fall.
    always @(negedge sclk) begin
        if (bitn == 8) hdr = mosi_frame[7:0];
        if (bitn == 16 && hdr[7] && hdr[6:0] == 7'h05) reg5 = mosi_frame[7:0];
        if (bitn >= 8 && bitn < 16) miso_r = slave_bit(hdr, bitn - 8, reg5);
        else                        miso_r = 1'b1;
    end

    task automatic run_txn(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                           input string tag);
        int n;
        int lat;
        int base;
        logic [15:0] exp_frame;
        base = rsp_count;
        @(negedge clk);
        bus.req_rw    = rw;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        check({tag, "_ready_wait"}, 32'(n < 100), 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_rw    = ~rw;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wd;
        n = 0;
        while (!bus.rsp_valid && n < 400) begin @(negedge clk); n++; end
        check({tag, "_rsp_wait"}, 32'(n < 400), 1);
        lat = cyc - hs_cyc;
        check({tag, "_latency"}, lat, 137);
        exp_frame = {rw, addr, (rw ? wd : 8'h00)};
        check({tag, "_mosi_frame"}, mosi_frame, exp_frame);
        check({tag, "_sclk_rises"}, bitn, 16);
        @(negedge clk);
        #1;
        check({tag, "_rsp_pulse_low"}, bus.rsp_valid, 0);
        check({tag, "_rsp_count"}, rsp_count - base, 1);
    endtask

    initial begin
        int n;
        int base_hs;
        int base_rsp;
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rdata", bus.rsp_rdata, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Read 0x01 -> 0xA5
        run_txn(1'b0, 7'h01, 8'h77, "rd01");
        check("rd01_rdata", bus.rsp_rdata, 8'hA5);

        // Write 0x05 <= 0x3C, rdata must keep 0xA5
        run_txn(1'b1, 7'h05, 8'h3C, "wr05");
        check("wr05_rdata_kept", bus.rsp_rdata, 8'hA5);

        // Read back the written register
        run_txn(1'b0, 7'h05, 8'h00, "rd05");
        check("rd05_rdata", bus.rsp_rdata, 8'h3C);

        // Unmatched address, miso idles high
        run_txn(1'b0, 7'h02, 8'h00, "rd02");
        check("rd02_rdata", bus.rsp_rdata, 8'hFF);

        // Back-to-back with req_valid held high
        repeat (2) @(negedge clk);
        mon_en        = 1'b1;
        base_hs       = hs_count;
        base_rsp      = rsp_count;
        bus.req_rw    = 1'b0;
        bus.req_addr  = 7'h01;
        bus.req_wdata = 8'h00;
        bus.req_valid = 1'b1;
        n = 0;
        while (hs_count < base_hs + 2 && n < 1000) begin @(negedge clk); #1; n++; end
        check("b2b_second_hs", 32'(n < 1000), 1);
        bus.req_valid = 1'b0;
        n = 0;
        while (rsp_count < base_rsp + 2 && n < 600) begin @(negedge clk); #1; n++; end
        check("b2b_rsp_wait", 32'(n < 600), 1);
        check("b2b_cs_gap_ok", 32'(min_run >= CS_GAP), 1);
        check("b2b_ready_only_idle", ready_bad, 0);
        check("b2b_rdata", bus.rsp_rdata, 8'hA5);
        mon_en = 1'b0;
        repeat (20) @(negedge clk);

        // Reset in the middle of a read
        base_rsp = rsp_count;
        @(negedge clk);
        bus.req_rw    = 1'b0;
        bus.req_addr  = 7'h01;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (bitn < 10 && n < 300) begin @(negedge clk); n++; end
        check("mid_rst_reach_bit10", 32'(n < 300), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cs", cs, 1);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_mosi", mosi, 0);
        check("mid_rst_ready", bus.req_ready, 1);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_rdata_clr", bus.rsp_rdata, 0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        check("mid_rst_no_rsp", rsp_count - base_rsp, 0);

        run_txn(1'b0, 7'h03, 8'h00, "rd03");
        check("rd03_rdata", bus.rsp_rdata, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
